// File: rtl/program_loader.sv
// Boot loader: takes a length-prefixed byte stream, writes little-endian words into instruction
// memory, verifies an XOR checksum and only then releases the core from reset.
module program_loader #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic                   imem_write_en,
    output logic [63:0]            imem_write_address,
    output logic [31:0]            imem_write_data,
    output logic                   core_run,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] words_loaded
);

    typedef enum logic [2:0] {
        StIdle, StLenLo, StLenHi, StData, StCheck, StDone, StError
    } state_e;

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] length_q;
    logic [COUNT_WIDTH-1:0] words_q;
    logic [1:0]             byte_idx_q;
    logic [23:0]            asm_q;
    logic [7:0]             csum_q;

    logic                   accept;
    logic                   start_ok;
    logic [COUNT_WIDTH-1:0] len_full;
    logic                   len_bad;
    logic                   word_done;
    logic                   last_word;

    assign accept    = rx_valid & rx_ready;
    assign start_ok  = start & ~busy;
    assign len_full  = COUNT_WIDTH'({rx_data, length_q[7:0]});
    assign len_bad   = (len_full == '0) || (32'(len_full) > DEPTH);
    assign word_done = accept && (state_q == StData) && (byte_idx_q == 2'd3);
    assign last_word = (words_q + COUNT_WIDTH'(1)) == length_q;

    assign words_loaded = words_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StError: if (start) state_d = StLenLo;
            StLenLo: if (accept) state_d = StLenHi;
            StLenHi: if (accept) state_d = len_bad ? StError : StData;
            StData:  if (word_done && last_word) state_d = StCheck;
            StCheck: if (accept) state_d = (rx_data == csum_q) ? StDone : StError;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        core_run = 1'b0;
        unique case (state_q)
            StLenLo, StLenHi, StData, StCheck: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            StDone: begin
                done     = 1'b1;
                core_run = 1'b1;
            end
            StError: error = 1'b1;
            default: ;
        endcase
    end

    // Datapath: header capture, word assembly, checksum and the registered write port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            length_q           <= '0;
            words_q            <= '0;
            byte_idx_q         <= '0;
            asm_q              <= '0;
            csum_q             <= '0;
            imem_write_en      <= 1'b0;
            imem_write_address <= '0;
            imem_write_data    <= '0;
        end else begin
            imem_write_en <= 1'b0;
            if (start_ok) begin
                words_q    <= '0;
                byte_idx_q <= '0;
                csum_q     <= '0;
            end
            if (accept) begin
                case (state_q)
                    StLenLo: length_q <= COUNT_WIDTH'(rx_data);
                    StLenHi: length_q <= len_full;
                    StData: begin
                        csum_q     <= csum_q ^ rx_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            imem_write_en      <= 1'b1;
                            imem_write_address <= {{(62 - COUNT_WIDTH){1'b0}}, words_q, 2'b00};
                            imem_write_data    <= {rx_data, asm_q};
                            words_q            <= words_q + COUNT_WIDTH'(1);
                        end else begin
                            asm_q[{byte_idx_q, 3'b000} +: 8] <= rx_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: nominal, bad checksum, bad length, flow control,
// reset mid-load and restart from DONE.
module tb_program_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_write_en;
    logic [63:0] imem_write_address;
    logic [31:0] imem_write_data;
    logic        core_run, busy, done, error;
    logic [15:0] words_loaded;

    int total = 0;
    int bad   = 0;

    logic [63:0] wr_addr[$];
    logic [31:0] wr_data[$];

    logic [7:0] nom [11] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                             8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};

    program_loader #(.DEPTH(256), .COUNT_WIDTH(16)) dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .rx_ready           (rx_ready),
        .imem_write_en      (imem_write_en),
        .imem_write_address (imem_write_address),
        .imem_write_data    (imem_write_data),
        .core_run           (core_run),
        .busy               (busy),
        .done               (done),
        .error              (error),
        .words_loaded       (words_loaded)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (imem_write_en) begin
            wr_addr.push_back(imem_write_address);
            wr_data.push_back(imem_write_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 20) begin
            tick();
            n++;
        end
        if (!rx_ready) check("rx_ready_timeout", 64'(rx_ready), 64'd1);
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic check_two_writes(input string tag);
        check({tag, "_wr_count"}, 64'(wr_addr.size()), 64'd2);
        if (wr_addr.size() >= 2) begin
            check({tag, "_wr0_addr"}, wr_addr[0], 64'h0);
            check({tag, "_wr0_data"}, 64'(wr_data[0]), 64'h00100513);
            check({tag, "_wr1_addr"}, wr_addr[1], 64'h4);
            check({tag, "_wr1_data"}, 64'(wr_data[1]), 64'h00200593);
        end
    endtask

    task automatic check_done(input string tag, input logic [15:0] words);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_core_run"}, 64'(core_run), 64'd1);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_words"}, 64'(words_loaded), 64'(words));
    endtask

    task automatic run_stream(input logic [7:0] csum, input int gap);
        pulse_start();
        for (int i = 0; i < 10; i++) send(nom[i], gap);
        send(csum, gap);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_core_run", 64'(core_run), 64'd0);
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        check("rst_wr_en", 64'(imem_write_en), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        reset = 1'b1;
        tick();

        // Byte offered while idle is ignored
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        repeat (2) tick();
        check("idle_rx_ready", 64'(rx_ready), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        rx_valid = 1'b0;
        tick();

        // Nominal load with write latency checks
        clear_writes();
        pulse_start();
        check("nom_busy", 64'(busy), 64'd1);
        check("nom_rx_ready", 64'(rx_ready), 64'd1);
        for (int i = 0; i < 10; i++) begin
            send(nom[i], 0);
            if (i == 5) begin
                check("nom_w0_en", 64'(imem_write_en), 64'd1);
                check("nom_w0_addr", imem_write_address, 64'h0);
                check("nom_w0_data", 64'(imem_write_data), 64'h00100513);
                check("nom_w0_words", 64'(words_loaded), 64'd1);
                check("nom_w0_rx_ready", 64'(rx_ready), 64'd1);
            end
            if (i == 9) begin
                check("nom_w1_en", 64'(imem_write_en), 64'd1);
                check("nom_w1_addr", imem_write_address, 64'h4);
                check("nom_w1_data", 64'(imem_write_data), 64'h00200593);
            end
        end
        check("nom_core_held", 64'(core_run), 64'd0);
        send(8'hB0, 0);
        check_done("nom", 16'd2);
        check("nom_rx_ready_after", 64'(rx_ready), 64'd0);
        check_two_writes("nom");

        // Bad checksum
        clear_writes();
        run_stream(8'hB1, 0);
        check("badck_error", 64'(error), 64'd1);
        check("badck_done", 64'(done), 64'd0);
        check("badck_core_run", 64'(core_run), 64'd0);
        check_two_writes("badck");

        // Zero length
        clear_writes();
        pulse_start();
        send(8'h00, 0);
        send(8'h00, 2);
        check("len0_error", 64'(error), 64'd1);
        check("len0_rx_ready", 64'(rx_ready), 64'd0);
        check("len0_writes", 64'(wr_addr.size()), 64'd0);

        // Length 257 exceeds capacity
        pulse_start();
        send(8'h01, 0);
        send(8'h01, 2);
        check("len257_error", 64'(error), 64'd1);
        check("len257_busy", 64'(busy), 64'd0);
        check("len257_rx_ready", 64'(rx_ready), 64'd0);
        check("len257_writes", 64'(wr_addr.size()), 64'd0);

        // Flow control bubbles, with an ignored start pulse during DATA
        clear_writes();
        pulse_start();
        for (int i = 0; i < 6; i++) send(nom[i], 3);
        pulse_start();
        check("mid_start_busy", 64'(busy), 64'd1);
        check("mid_start_words", 64'(words_loaded), 64'd1);
        for (int i = 6; i < 10; i++) send(nom[i], 3);
        send(8'hB0, 0);
        check_done("flow", 16'd2);
        check_two_writes("flow");

        // Reset mid-load
        pulse_start();
        for (int i = 0; i < 5; i++) send(nom[i], 0);
        check("midrst_busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_rx_ready", 64'(rx_ready), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_error", 64'(error), 64'd0);
        check("midrst_core_run", 64'(core_run), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        clear_writes();
        run_stream(8'hB0, 0);
        check_done("after_rst", 16'd2);
        check_two_writes("after_rst");

        // Restart from DONE
        clear_writes();
        pulse_start();
        check("restart_core_run", 64'(core_run), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_done", 64'(done), 64'd0);
        check("restart_words", 64'(words_loaded), 64'd0);
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'h6F, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h6F, 0);
        check_done("restart", 16'd1);
        check("restart_wr_count", 64'(wr_addr.size()), 64'd1);
        if (wr_addr.size() >= 1) begin
            check("restart_wr_addr", wr_addr[0], 64'h0);
            check("restart_wr_data", 64'(wr_data[0]), 64'h0000006F);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
